// File: rtl/sha256_pipe.sv
// Fully unrolled SHA-256 pipeline: one registered round per stage, built-in padding, one digest per clock.
// Optional define SHA256_PIPE_MSG_REG_EN inserts an input register in front of round 0 (+1 cycle latency).
package sha256_pipe_pkg;
  typedef logic [0:7][31:0]  words8_t;
  typedef logic [0:15][31:0] words16_t;

  typedef struct packed {
    words8_t  st;  // working variables a..h
    words16_t w;   // schedule window, w[0] is W[t] of this round
    words8_t  cv;  // chaining value consumed by the feed-forward stage
  } stage_t;

  localparam words8_t IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic words8_t add8(input words8_t x, input words8_t y);
    words8_t s;
    for (int i = 0; i < 8; i++) s[i] = x[i] + y[i];
    return s;
  endfunction
endpackage

module sha256_round import sha256_pipe_pkg::*; #(
  parameter int R = 0
) (
  input  logic   clk,
  input  stage_t d,
  output stage_t q
);
  stage_t      q_d, q_q;
  logic [31:0] s0, s1, ch, maj, t1, t2, ss0, ss1;

  always_comb begin
    s1     = rotr(d.st[4], 6) ^ rotr(d.st[4], 11) ^ rotr(d.st[4], 25);
    ch     = (d.st[4] & d.st[5]) ^ (~d.st[4] & d.st[6]);
    t1     = d.st[7] + s1 + ch + K[R] + d.w[0];
    s0     = rotr(d.st[0], 2) ^ rotr(d.st[0], 13) ^ rotr(d.st[0], 22);
    maj    = (d.st[0] & d.st[1]) ^ (d.st[0] & d.st[2]) ^ (d.st[1] & d.st[2]);
    t2     = s0 + maj;
    ss0    = rotr(d.w[1], 7) ^ rotr(d.w[1], 18) ^ (d.w[1] >> 3);
    ss1    = rotr(d.w[14], 17) ^ rotr(d.w[14], 19) ^ (d.w[14] >> 10);
    q_d.st = {t1 + t2, d.st[0], d.st[1], d.st[2], d.st[3] + t1, d.st[4], d.st[5], d.st[6]};
    // window slides by one: W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t]
    q_d.w  = {d.w[1:15], ss1 + d.w[9] + ss0 + d.w[0]};
    q_d.cv = d.cv;
  end

  always_ff @(posedge clk) q_q <= q_d;

  assign q = q_q;
endmodule

module sha256_pipe import sha256_pipe_pkg::*; #(
  parameter int MSG_WIDTH = 512
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [MSG_WIDTH-1:0] in_data,
  output logic                 out_valid,
  output logic [255:0]         hash
);
  localparam int B = (MSG_WIDTH > 256) ? 2 : 1;
`ifdef SHA256_PIPE_MSG_REG_EN
  localparam int IN_REGS = 1;
`else
  localparam int IN_REGS = 0;
`endif
  localparam int L = 65 * B + IN_REGS;
  localparam words16_t PAD2 = {32'h8000_0000, 448'h0, 32'h0000_0200};

  logic [MSG_WIDTH-1:0] msg;
  words16_t             blk0;
  stage_t               rs [B][65];
  logic [L:1]           vld_pipe_q;
  logic [255:0]         hash_q, hash_d;

`ifdef SHA256_PIPE_MSG_REG_EN
  logic [MSG_WIDTH-1:0] msg_q;
  always_ff @(posedge clk) msg_q <= in_data;
  assign msg = msg_q;
`else
  assign msg = in_data;
`endif

  // One valid bit per register stage; the input register (if present) is vld_pipe_q[1].
  always_ff @(posedge clk) begin
    if (!reset) vld_pipe_q <= '0;
    else        vld_pipe_q <= {vld_pipe_q[L-1:1], in_valid};
  end

  if (MSG_WIDTH == 256) begin : g_pad256
    assign blk0 = {msg, 32'h8000_0000, 160'h0, 64'd256};
  end else begin : g_pad512
    assign blk0 = msg;
  end

  assign rs[0][0] = '{st: IV, w: blk0, cv: IV};

  for (genvar b = 0; b < B; b++) begin : g_blk
    for (genvar r = 0; r < 64; r++) begin : g_rnd
      sha256_round #(.R(r)) u_rnd (.clk(clk), .d(rs[b][r]), .q(rs[b][r+1]));
    end
  end

  if (B == 2) begin : g_ff1
    // Block-1 result becomes both the start state and the chaining value of the padding block.
    stage_t ff_q;
    always_ff @(posedge clk) begin
      ff_q.st <= add8(rs[0][64].st, rs[0][64].cv);
      ff_q.cv <= add8(rs[0][64].st, rs[0][64].cv);
      ff_q.w  <= PAD2;
    end
    assign rs[1][0] = ff_q;
  end

  assign hash_d = add8(rs[B-1][64].st, rs[B-1][64].cv);

  always_ff @(posedge clk) begin
    if (!reset) hash_q <= '0;
    else        hash_q <= hash_d;
  end

  assign hash      = hash_q;
  assign out_valid = vld_pipe_q[L];
endmodule

// File: tb/tb_sha256_pipe.sv
// Bench for sha256_pipe: 256- and 512-bit instances side by side, scoreboard against a software SHA-256 model.
// Honours SHA256_PIPE_MSG_REG_EN when the design is built with it (one extra cycle of latency).
module tb_sha256_pipe;
`ifdef SHA256_PIPE_MSG_REG_EN
  localparam int XTRA = 1;
`else
  localparam int XTRA = 0;
`endif
  localparam int L256 = 65 + XTRA;
  localparam int L512 = 130 + XTRA;
  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] Z256 = 256'h66687aadf862bd776c8fc18b8e9f8e20089714856ee233b3902a591d0d5f2925;
  localparam logic [255:0] Z512 = 256'hf5a5fd42d16a20302798ef6ed309979b43003d2320d9f0e8ea9831a92759fb4b;
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef struct { logic [255:0] h; int due; } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         v256 = 1'b0, v512 = 1'b0;
  logic [255:0] d256 = '0;
  logic [511:0] d512 = '0;
  logic         ov256, ov512;
  logic [255:0] h256, h512;
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  exp_t         q256[$], q512[$];
  exp_t         e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sha256_pipe #(.MSG_WIDTH(256)) dut256 (
    .clk(clk), .reset(reset), .in_valid(v256), .in_data(d256), .out_valid(ov256), .hash(h256));
  sha256_pipe #(.MSG_WIDTH(512)) dut512 (
    .clk(clk), .reset(reset), .in_valid(v512), .in_data(d512), .out_valid(ov512), .hash(h512));

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  t1, t2;
    logic [255:0] res;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
    return res;
  endfunction

  function automatic logic [255:0] ref256(input logic [255:0] m);
    return compress(IV, {m, 32'h8000_0000, 160'h0, 64'd256});
  endfunction

  function automatic logic [255:0] ref512(input logic [511:0] m);
    return compress(compress(IV, m), {32'h8000_0000, 416'h0, 64'd512});
  endfunction

  // Scoreboard monitor: every pulse must match the queue head due this very cycle.
  always @(negedge clk) begin
    if (ov256) begin
      checks++;
      if (q256.size() == 0 || q256[0].due != cyc) begin
        errors++;
        $display("FAIL out256_pulse cyc=%0d: got pulse, expected none", cyc);
      end else begin
        e = q256.pop_front();
        checks++;
        if (h256 !== e.h) begin
          errors++;
          $display("FAIL hash256 cyc=%0d: got %h expected %h", cyc, h256, e.h);
        end
      end
    end else if (q256.size() > 0 && q256[0].due <= cyc) begin
      checks++; errors++;
      $display("FAIL out256_pulse cyc=%0d: got no pulse, expected one due at %0d", cyc, q256[0].due);
      void'(q256.pop_front());
    end
    if (ov512) begin
      checks++;
      if (q512.size() == 0 || q512[0].due != cyc) begin
        errors++;
        $display("FAIL out512_pulse cyc=%0d: got pulse, expected none", cyc);
      end else begin
        e = q512.pop_front();
        checks++;
        if (h512 !== e.h) begin
          errors++;
          $display("FAIL hash512 cyc=%0d: got %h expected %h", cyc, h512, e.h);
        end
      end
    end else if (q512.size() > 0 && q512[0].due <= cyc) begin
      checks++; errors++;
      $display("FAIL out512_pulse cyc=%0d: got no pulse, expected one due at %0d", cyc, q512[0].due);
      void'(q512.pop_front());
    end
  end

  // Output lands L edges after the negedge the input was driven on (sampling edge counts as the first).
  task automatic send(input bit v);
    logic [511:0] r;
    @(negedge clk);
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    v256 = v; v512 = v; d256 = r[511:256]; d512 = r;
    if (v) begin
      q256.push_back('{h: ref256(r[511:256]), due: cyc + L256});
      q512.push_back('{h: ref512(r), due: cyc + L512});
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) send(1'b1);
    q256.delete(); q512.delete();
    @(negedge clk);
    v256 = 1'b0; v512 = 1'b0;
    checks += 4;
    if (ov256 !== 1'b0) begin errors++; $display("FAIL reset_ov256: got %b expected 0", ov256); end
    if (ov512 !== 1'b0) begin errors++; $display("FAIL reset_ov512: got %b expected 0", ov512); end
    if (h256 !== '0) begin errors++; $display("FAIL reset_h256: got %h expected 0", h256); end
    if (h512 !== '0) begin errors++; $display("FAIL reset_h512: got %h expected 0", h512); end
    reset = 1'b1;
  endtask

  task automatic test_zero_vector();
    @(negedge clk);
    v256 = 1'b1; v512 = 1'b1; d256 = '0; d512 = '0;
    q256.push_back('{h: Z256, due: cyc + L256});
    q512.push_back('{h: Z512, due: cyc + L512});
    for (int i = 0; i < 3; i++) send(1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 200; i++) send(1'b1);
    send(1'b0);
  endtask

  task automatic test_sparse();
    bit pat [12] = '{1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 1};
    foreach (pat[i]) send(pat[i]);
    send(1'b0);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 50; i++) send(1'b1);
    @(negedge clk);
    #1;
    reset = 1'b0; v256 = 1'b1; v512 = 1'b1;
    q256.delete(); q512.delete();
    @(negedge clk);
    checks += 4;
    if (ov256 !== 1'b0) begin errors++; $display("FAIL midreset_ov256: got %b expected 0", ov256); end
    if (ov512 !== 1'b0) begin errors++; $display("FAIL midreset_ov512: got %b expected 0", ov512); end
    if (h256 !== '0) begin errors++; $display("FAIL midreset_h256: got %h expected 0", h256); end
    if (h512 !== '0) begin errors++; $display("FAIL midreset_h512: got %h expected 0", h512); end
    reset = 1'b1; v256 = 1'b0; v512 = 1'b0;
    send(1'b1);
    send(1'b0);
  endtask

  task automatic test_drain();
    int n = 0;
    while ((q256.size() != 0 || q512.size() != 0) && n < 400) begin
      send(1'b0);
      n++;
    end
    for (int i = 0; i < 10; i++) send(1'b0);
    checks++;
    if (q256.size() != 0 || q512.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending, expected 0/0", q256.size(), q512.size());
    end
  endtask

  initial begin
    test_reset();
    test_zero_vector();
    test_drain();
    test_back_to_back();
    test_drain();
    test_sparse();
    test_drain();
    test_mid_reset();
    test_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
